// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB4 master port among NUM_REQ requesters.
// Optional ACCESS-phase timeout abort is enabled with `define APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                pclk,
  input  logic                                presetn,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_strb,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic                                rsp_err,
  output logic [ADDR_WIDTH-1:0]               paddr,
  output logic [2:0]                          pprot,
  output logic                                psel,
  output logic                                penable,
  output logic                                pwrite,
  output logic [DATA_WIDTH-1:0]               pwdata,
  output logic [DATA_WIDTH/8-1:0]             pstrb,
  input  logic [DATA_WIDTH-1:0]               prdata,
  input  logic                                pready,
  input  logic                                pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                 state_reg;
  logic [IDX_W-1:0]       rr_ptr_reg;   // requester with highest priority next
  logic [IDX_W-1:0]       grant_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic                   write_reg;
  logic [DATA_WIDTH-1:0]  wdata_reg;
  logic [STRB_W-1:0]      strb_reg;
  logic                   psel_reg;
  logic                   penable_reg;
  logic [NUM_REQ-1:0]     rsp_valid_reg;
  logic [DATA_WIDTH-1:0]  rsp_rdata_reg;
  logic                   rsp_err_reg;

  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];
  logic [STRB_W-1:0]      strb_arr  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign strb_arr[gi]  = req_strb[gi*STRB_W +: STRB_W];
  end

  // Scan upward from the rotating pointer; first asserted request wins.
  logic [IDX_W-1:0] winner;
  logic             found;
  logic [IDX_W-1:0] cand;
  int               idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign req_ready = (state_reg == IDLE && found) ? (NUM_REQ'(1) << winner) : '0;

  logic timeout_hit;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_reg;

  // Abort on the edge where the wait count would reach TIMEOUT_CYCLES.
  assign timeout_hit = !pready && (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      to_cnt_reg <= '0;
    end else if (state_reg != ACCESS) begin
      to_cnt_reg <= '0;
    end else if (!pready) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      addr_reg      <= '0;
      write_reg     <= 1'b0;
      wdata_reg     <= '0;
      strb_reg      <= '0;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (found) begin
            addr_reg    <= addr_arr[winner];
            write_reg   <= req_write[winner];
            wdata_reg   <= wdata_arr[winner];
            strb_reg    <= req_write[winner] ? strb_arr[winner] : '0;
            grant_reg   <= winner;
            rr_ptr_reg  <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            psel_reg    <= 1'b1;
            penable_reg <= 1'b0;
            state_reg   <= SETUP;
          end
        end
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_rdata_reg <= write_reg ? '0 : prdata;
            rsp_err_reg   <= pslverr;
            rsp_valid_reg <= NUM_REQ'(1) << grant_reg;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            state_reg     <= IDLE;
          end else if (timeout_hit) begin
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b1;
            rsp_valid_reg <= NUM_REQ'(1) << grant_reg;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign paddr     = addr_reg;
  assign pprot     = 3'b000;
  assign psel      = psel_reg;
  assign penable   = penable_reg;
  assign pwrite    = write_reg;
  assign pwdata    = wdata_reg;
  assign pstrb     = strb_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule
